addr_decoder: RTL and testbench
===============================

Name: addr_decoder

Overview:
- CPU-side memory-map decoder for the vector-arcade core; sits between the 6502 core and its memories and peripherals.
- Routes the core address, write data and write strobes to five memory/peripheral buses: program RAM, program ROM, vector memory, math box and POKEY.
- Muxes read data back to the core, provides the input ports (IN0, DSW0, DSW1), and generates the vector-generator go/reset strobes.

Parameters:
- None. Bus indices are fixed: BRAM_PROG_RAM=0, BRAM_PROG_ROM=1, BRAM_VECTOR=2, BRAM_MATH=3, BRAM_POKEY=4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  CPU clock enable (3 MHz tick)
- addr  in  16  core address; bit 15 ignored
- dataFromCore  in  8  core write data
- we  in  1  core write strobe
- dataFromBram  in  5x8  read data from each bus, indexed by bus index
- halt  in  1  vector generator halted
- clk_3KHz  in  1  3 kHz square wave
- self_test  in  1  test switch, active low (1 = normal)
- option_switch  in  16  DIP switches
- coin  in  1  coin switch, 1 = pressed
- dataToCore  out  8  read data to the core
- addrToBram  out  5x16  address to each bus
- dataToBram  out  5x8  write data to each bus
- weEnBram  out  5  per-bus write enable
- vggo  out  1  vector generator start strobe
- vgrst  out  1  vector generator reset strobe

Behaviour:
- Decode uses a[14:0] and is combinational:
  - 0000-07FF: PROG_RAM (1 KB mirrored)
  - 0800: IN0 (read)
  - 0A00: DSW0 (read)
  - 0C00: DSW1 (read)
  - 1200: VGGO (write)
  - 1600: VGRST (write)
  - 1800-181F: MATH (reads)
  - 1860-187F: MATH (writes)
  - 1820-182F: POKEY
  - 1840: POKEY (output-latch write)
  - 2000-3FFF: VECTOR
  - 5000-7FFF: PROG_ROM
  - Everything else: unmapped.
- addrToBram[i] = addr for every i, unmodified. Consumers rebase or slice the address themselves.
- dataToBram[i] = dataFromCore for every i.
- weEnBram[i] = we AND (address in bus i's region). Combinational; never asserted for unmapped, IN0, DSW or PROG_ROM addresses.
- Read path has 1 enabled-cycle latency, matching the synchronous memories:
  - On clk_en, register the decoded source select.
  - On the same clk_en, register the I/O values for the IN0/DSW sources.
  - dataToCore = mux(registered select). It is valid from the clock after the clk_en edge and holds until the next clk_en.
- Read data per source:
  - Memory-bus sources return dataFromBram[i].
  - DSW0 returns option_switch[7:0].
  - DSW1 returns option_switch[15:8].
  - Unmapped addresses return 8'h00.
- IN0 bit map:
  - bit7 = clk_3KHz
  - bit6 = halt
  - bit5 = 1 (diag step off)
  - bit4 = self_test
  - bit3 = 1 (slam)
  - bit2 = 1
  - bit1 = ~coin (left coin, active low)
  - bit0 = 1
- Strobes:
  - On a clk_en with we=1 at 1200, vggo is registered to 1. It is held until the next clk_en, at which it reloads from that cycle's decode, giving exactly one CPU-cycle pulse.
  - vgrst behaves identically at 1600.
  - Writes to 1000 (coin counter) and 1400 (watchdog) are accepted and ignored.
- Reset (synchronous, takes precedence over clk_en):
  - vggo=0, vgrst=0.
  - Registered select = unmapped, so dataToCore=8'h00.
- Mirror rule: an address with bit15 set decodes the same as with bit15 clear.

Test Plan:
- Reset, then read 0x0000 with dataFromBram[0]=8'h5A → weEnBram=0; after the next clk_en, dataToCore=8'h5A.
- Write 0x2345 with data 8'hC3, we=1 → weEnBram=5'b00100, dataToBram[2]=8'hC3, addrToBram[2]=16'h2345.
- Read 0x0800 with halt=1, clk_3KHz=1, self_test=1, coin=1 → dataToCore=8'hFD. With coin=0 → 8'hFF.
- Read 0x0A00 / 0x0C00 with option_switch=16'hA55A → dataToCore = 8'h5A / 8'hA5.
- Write 0x1200 → vggo=1 for exactly one clk_en period, vgrst=0. Write 0x1600 → vgrst pulse. Assert rst mid-pulse → both 0 on the next clock.
- Write 0x1822 → weEnBram[4]=1. Write 0x1840 → weEnBram[4]=1. Write 0x1860 → weEnBram[3]=1. Read 0x9000 (bit15 mirror of 0x1000) → weEnBram=0, dataToCore=8'h00.

Source files
------------

// File: rtl/addr_decoder.sv
// CPU memory-map decoder for the vector-arcade core: routes core accesses to five
// memory/peripheral buses, muxes read data back, and generates vector-generator strobes.
module addr_decoder (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [15:0]     addr,
    input  logic [7:0]      dataFromCore,
    input  logic            we,
    input  logic [4:0][7:0] dataFromBram,
    input  logic            halt,
    input  logic            clk_3KHz,
    input  logic            self_test,
    input  logic [15:0]     option_switch,
    input  logic            coin,
    output logic [7:0]      dataToCore,
    output logic [4:0][15:0] addrToBram,
    output logic [4:0][7:0] dataToBram,
    output logic [4:0]      weEnBram,
    output logic            vggo,
    output logic            vgrst
);

    localparam int unsigned BRAM_PROG_RAM = 0;
    localparam int unsigned BRAM_PROG_ROM = 1;
    localparam int unsigned BRAM_VECTOR   = 2;
    localparam int unsigned BRAM_MATH     = 3;
    localparam int unsigned BRAM_POKEY    = 4;

    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_PROG_RAM,
        SRC_PROG_ROM,
        SRC_VECTOR,
        SRC_MATH,
        SRC_POKEY,
        SRC_IN0,
        SRC_DSW0,
        SRC_DSW1
    } src_e;

    logic [14:0] a;
    assign a = addr[14:0];

    logic hit_ram, hit_rom, hit_vec, hit_math_rd, hit_math_wr, hit_pokey;
    logic hit_in0, hit_dsw0, hit_dsw1, hit_vggo, hit_vgrst;

    always_comb begin
        hit_ram     = (a <= 15'h07FF);
        hit_in0     = (a == 15'h0800);
        hit_dsw0    = (a == 15'h0A00);
        hit_dsw1    = (a == 15'h0C00);
        hit_vggo    = (a == 15'h1200);
        hit_vgrst   = (a == 15'h1600);
        hit_math_rd = (a >= 15'h1800) && (a <= 15'h181F);
        hit_math_wr = (a >= 15'h1860) && (a <= 15'h187F);
        hit_pokey   = ((a >= 15'h1820) && (a <= 15'h182F)) || (a == 15'h1840);
        hit_vec     = (a >= 15'h2000) && (a <= 15'h3FFF);
        hit_rom     = (a >= 15'h5000) && (a <= 15'h7FFF);
    end

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            addrToBram[i] = addr;
            dataToBram[i] = dataFromCore;
        end
        weEnBram                = '0;
        weEnBram[BRAM_PROG_RAM] = we && hit_ram;
        weEnBram[BRAM_VECTOR]   = we && hit_vec;
        weEnBram[BRAM_MATH]     = we && hit_math_wr;
        weEnBram[BRAM_POKEY]    = we && hit_pokey;
    end

    src_e       src_dec;
    logic [7:0] in0_val;

    always_comb begin
        src_dec = SRC_NONE;
        if (hit_ram)          src_dec = SRC_PROG_RAM;
        else if (hit_rom)     src_dec = SRC_PROG_ROM;
        else if (hit_vec)     src_dec = SRC_VECTOR;
        else if (hit_math_rd) src_dec = SRC_MATH;
        else if (hit_pokey)   src_dec = SRC_POKEY;
        else if (hit_in0)     src_dec = SRC_IN0;
        else if (hit_dsw0)    src_dec = SRC_DSW0;
        else if (hit_dsw1)    src_dec = SRC_DSW1;
        in0_val = {clk_3KHz, halt, 1'b1, self_test, 1'b1, 1'b1, ~coin, 1'b1};
    end

    src_e       src_q, src_d;
    logic [7:0] io_q, io_d;
    logic       vggo_q, vggo_d;
    logic       vgrst_q, vgrst_d;

    // I/O values are captured alongside the select so they line up with the memory latency.
    always_comb begin
        src_d   = src_q;
        io_d    = io_q;
        vggo_d  = vggo_q;
        vgrst_d = vgrst_q;
        if (clk_en) begin
            src_d   = src_dec;
            vggo_d  = we && hit_vggo;
            vgrst_d = we && hit_vgrst;
            unique case (src_dec)
                SRC_IN0:  io_d = in0_val;
                SRC_DSW0: io_d = option_switch[7:0];
                SRC_DSW1: io_d = option_switch[15:8];
                default:  io_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= SRC_NONE;
            io_q    <= '0;
            vggo_q  <= 1'b0;
            vgrst_q <= 1'b0;
        end else begin
            src_q   <= src_d;
            io_q    <= io_d;
            vggo_q  <= vggo_d;
            vgrst_q <= vgrst_d;
        end
    end

    always_comb begin
        dataToCore = '0;
        unique case (src_q)
            SRC_PROG_RAM: dataToCore = dataFromBram[BRAM_PROG_RAM];
            SRC_PROG_ROM: dataToCore = dataFromBram[BRAM_PROG_ROM];
            SRC_VECTOR:   dataToCore = dataFromBram[BRAM_VECTOR];
            SRC_MATH:     dataToCore = dataFromBram[BRAM_MATH];
            SRC_POKEY:    dataToCore = dataFromBram[BRAM_POKEY];
            SRC_IN0, SRC_DSW0, SRC_DSW1: dataToCore = io_q;
            default:      dataToCore = '0;
        endcase
    end

    assign vggo  = vggo_q;
    assign vgrst = vgrst_q;

endmodule

// File: tb/tb_addr_decoder.sv
// Directed-vector self-checking bench for addr_decoder.
module tb_addr_decoder;

    logic             clk;
    logic             rst;
    logic             clk_en;
    logic [15:0]      addr;
    logic [7:0]       dataFromCore;
    logic             we;
    logic [4:0][7:0]  dataFromBram;
    logic             halt;
    logic             clk_3KHz;
    logic             self_test;
    logic [15:0]      option_switch;
    logic             coin;
    logic [7:0]       dataToCore;
    logic [4:0][15:0] addrToBram;
    logic [4:0][7:0]  dataToBram;
    logic [4:0]       weEnBram;
    logic             vggo;
    logic             vgrst;

    int checks   = 0;
    int failures = 0;

    addr_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .addr          (addr),
        .dataFromCore  (dataFromCore),
        .we            (we),
        .dataFromBram  (dataFromBram),
        .halt          (halt),
        .clk_3KHz      (clk_3KHz),
        .self_test     (self_test),
        .option_switch (option_switch),
        .coin          (coin),
        .dataToCore    (dataToCore),
        .addrToBram    (addrToBram),
        .dataToBram    (dataToBram),
        .weEnBram      (weEnBram),
        .vggo          (vggo),
        .vgrst         (vgrst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock with the given clk_en, then settle just past the edge.
    task automatic tick(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
    endtask

    task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
        addr         = a;
        we           = w;
        dataFromCore = d;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        clk_en        = 1'b0;
        addr          = '0;
        dataFromCore  = '0;
        we            = 1'b0;
        halt          = 1'b0;
        clk_3KHz      = 1'b0;
        self_test     = 1'b1;
        option_switch = '0;
        coin          = 1'b0;
        dataFromBram[0] = 8'h5A;
        dataFromBram[1] = 8'h11;
        dataFromBram[2] = 8'h22;
        dataFromBram[3] = 8'h33;
        dataFromBram[4] = 8'h44;

        tick(1'b1);
        tick(1'b0);
        check("rst_data", dataToCore, 8'h00);
        check("rst_vggo", vggo, 1'b0);
        check("rst_vgrst", vgrst, 1'b0);
        rst = 1'b0;

        // Program RAM read with one enabled-cycle latency
        drive(16'h0000, 1'b0, 8'h00);
        check("ram_rd_we", weEnBram, 5'b00000);
        tick(1'b1);
        check("ram_rd_data", dataToCore, 8'h5A);
        tick(1'b0);
        check("ram_rd_hold", dataToCore, 8'h5A);

        // Vector memory write routing
        drive(16'h2345, 1'b1, 8'hC3);
        check("vec_we", weEnBram, 5'b00100);
        check("vec_data", dataToBram[2], 8'hC3);
        check("vec_addr", addrToBram[2], 16'h2345);
        check("ram_addr_bcast", addrToBram[0], 16'h2345);
        check("pokey_data_bcast", dataToBram[4], 8'hC3);

        // IN0
        drive(16'h0800, 1'b0, 8'h00);
        halt = 1'b1; clk_3KHz = 1'b1; self_test = 1'b1; coin = 1'b1;
        check("in0_we", weEnBram, 5'b00000);
        tick(1'b1);
        check("in0_coin1", dataToCore, 8'hFD);
        coin = 1'b0;
        tick(1'b1);
        check("in0_coin0", dataToCore, 8'hFF);
        coin = 1'b1;
        tick(1'b0);
        check("in0_latched", dataToCore, 8'hFF);
        halt = 1'b0; clk_3KHz = 1'b0; self_test = 1'b0; coin = 1'b0;
        tick(1'b1);
        check("in0_low", dataToCore, 8'h2F);

        // DIP switches
        option_switch = 16'hA55A;
        drive(16'h0A00, 1'b0, 8'h00);
        tick(1'b1);
        check("dsw0", dataToCore, 8'h5A);
        drive(16'h0C00, 1'b0, 8'h00);
        tick(1'b1);
        check("dsw1", dataToCore, 8'hA5);

        // Other read sources, including the bit15 mirror
        drive(16'h5000, 1'b1, 8'h77);
        check("rom_we", weEnBram, 5'b00000);
        tick(1'b1);
        check("rom_rd", dataToCore, 8'h11);
        drive(16'h1805, 1'b0, 8'h00);
        tick(1'b1);
        check("math_rd", dataToCore, 8'h33);
        drive(16'hA000, 1'b0, 8'h00);
        tick(1'b1);
        check("vec_mirror_rd", dataToCore, 8'h22);

        // vggo pulse
        drive(16'h1200, 1'b1, 8'h00);
        check("vggo_we", weEnBram, 5'b00000);
        tick(1'b1);
        check("vggo_set", vggo, 1'b1);
        check("vggo_vgrst", vgrst, 1'b0);
        drive(16'h0000, 1'b0, 8'h00);
        tick(1'b0);
        tick(1'b0);
        check("vggo_hold", vggo, 1'b1);
        tick(1'b1);
        check("vggo_clear", vggo, 1'b0);

        // vgrst pulse, reset mid-pulse
        drive(16'h1600, 1'b1, 8'h00);
        tick(1'b1);
        check("vgrst_set", vgrst, 1'b1);
        check("vgrst_vggo", vggo, 1'b0);
        drive(16'h1200, 1'b1, 8'h00);
        rst = 1'b1;
        tick(1'b1);
        check("rst_mid_vgrst", vgrst, 1'b0);
        check("rst_mid_vggo", vggo, 1'b0);
        check("rst_mid_data", dataToCore, 8'h00);
        rst = 1'b0;

        // POKEY / math write enables
        drive(16'h1822, 1'b1, 8'h00);
        check("pokey_we", weEnBram, 5'b10000);
        drive(16'h1840, 1'b1, 8'h00);
        check("pokey_latch_we", weEnBram, 5'b10000);
        drive(16'h1860, 1'b1, 8'h00);
        check("math_we", weEnBram, 5'b01000);
        drive(16'h87FF, 1'b1, 8'h00);
        check("ram_mirror_we", weEnBram, 5'b00001);
        drive(16'h1822, 1'b0, 8'h00);
        check("pokey_no_we", weEnBram, 5'b00000);

        // Coin counter mirror: unmapped
        drive(16'h9000, 1'b1, 8'hFF);
        check("mirror_unmapped_we", weEnBram, 5'b00000);
        tick(1'b1);
        check("mirror_unmapped_rd", dataToCore, 8'h00);
        check("coin_ctr_vggo", vggo, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
